wrr_arbiter: RTL
================

Name: wrr_arbiter

Overview:
Weighted round-robin arbiter. It grants one of NUM_PORTS requesting actors ownership of a shared resource and holds the grant for a per-port number of transactions. Each transaction is counted by a done pulse from the owner. This is the successor to the plain round-robin arbiter: it adds per-port weights, transaction-level grant hold, a binary owner index and zero-bubble handover. It sits between bus masters and a shared slave or bus mux, and grant_idx drives the mux select directly.

Parameters:
NUM_PORTS, 6, number of requesting actors (>=2).
WEIGHT_WIDTH, 4, width of each per-port weight field.
IDX_WIDTH, $clog2(NUM_PORTS), width of grant_idx (derived; do not override).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
request  input  NUM_PORTS  bit i high = port i wants ownership; held until the port is finished.
weight  input  NUM_PORTS*WEIGHT_WIDTH  port i weight in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; grant covers weight+1 transactions.
done  input  1  pulse from the current owner marking the end of one transaction.
grant  output  NUM_PORTS  registered one-hot owner; all-zero when idle.
grant_idx  output  IDX_WIDTH  registered binary index of the owner; holds its last value when idle.
active  output  1  registered; high while any grant bit is high.

Behaviour:
- Reset (rst high at an edge): grant=0, grant_idx=0, active=0, credit=0, pointer=0, state=IDLE. Reset mid-grant drops ownership at that edge. The first post-reset search starts at port 0.
- State machine: IDLE and OWNED.
- Selection: search for the first requesting port at or after pointer, in increasing index order, wrapping modulo NUM_PORTS.
- IDLE: if request != 0 at an edge, grant the selected port at that edge. Load credit = weight[sel], set state=OWNED. Latency is one cycle: request is sampled at edge k and grant is visible after edge k.
- OWNED, owner's request low at an edge: release. Remaining credit is discarded and done is ignored that cycle.
- OWNED, done high, owner's request high, credit > 0: credit decrements and the grant is held.
- OWNED, done high, owner's request high, credit == 0: release.
- Release: pointer = (owner+1) mod NUM_PORTS. At the same edge, search from the new pointer.
  - If a requester is found, grant it with a new credit load (zero-bubble handover). The old owner competes last and is re-granted only if it is the sole requester.
  - If no requester is found: grant=0, active=0, state=IDLE, grant_idx unchanged.
- done while IDLE is ignored. Multiple done pulses count one per cycle.
- Weight is sampled only at grant load. Later changes take effect at that port's next grant. Weight 0 means exactly one transaction.
- Credit counter width is WEIGHT_WIDTH. It never underflows.
- Invariants: grant is always one-hot or zero. active == |grant. When active is high, grant[grant_idx] == 1. A non-owner request never preempts the owner.
- Fairness: a continuously requesting port is granted within NUM_PORTS-1 releases.

Test Plan:
- Reset then request=000001, weight0=2 -> grant=000001 one cycle later, grant_idx=0, active=1. It stays granted through 2 done pulses and releases on the 3rd, after which grant=0 and active=0.
- request=111111, all weights 0, done every cycle -> grant rotates 0,1,2,3,4,5,0 with no idle cycle between owners. grant_idx tracks the owner.
- Port 2 owning with weight2=5; drop request[2] after 1 done -> grant moves to the next requester (e.g. port 4 if request=010100) at that edge. Leftover credit is discarded.
- Only port 3 requesting with weight3=1; after 2 dones -> grant is re-issued to port 3 with no bubble, and credit reloads from the current weight3.
- Assert rst while port 1 owns mid-burst -> next cycle grant=0, active=0, grant_idx=0. A subsequent request=000110 grants port 1, not port 2.
- done pulses while idle, then request=100000 with weight5=0 -> port 5 is granted and needs exactly one done to release. The earlier pulses have no effect.

Source files
------------

// File: rtl/wrr_arbiter.sv
// wrr_arbiter
//   Weighted round-robin arbiter. Grants one of NUM_PORTS requesters ownership
//   of a shared resource and holds the grant for weight+1 transactions, each
//   marked by a done pulse from the owner. On release the grant hands over in
//   the same cycle to the next requester after the old owner (zero bubble).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   request    in   [NUM_PORTS]   per-port ownership request
//   weight     in   [NUM_PORTS*WEIGHT_WIDTH]  per-port weight, port i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   done       in   end-of-transaction pulse from the current owner
//   grant      out  [NUM_PORTS]   registered one-hot owner, zero when idle
//   grant_idx  out  [IDX_WIDTH]   registered binary owner index, holds when idle
//   active     out  registered, high while a grant is outstanding
module wrr_arbiter #(
  parameter int NUM_PORTS    = 6,
  parameter int WEIGHT_WIDTH = 4,
  parameter int IDX_WIDTH    = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              request,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
  input  logic                              done,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [IDX_WIDTH-1:0]              grant_idx,
  output logic                              active
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                  state;
  logic [IDX_WIDTH-1:0]    pointer;
  logic [WEIGHT_WIDTH-1:0] credit;

  logic [IDX_WIDTH-1:0]    next_ptr;
  logic [IDX_WIDTH-1:0]    idle_sel;
  logic [IDX_WIDTH-1:0]    rel_sel;
  logic                    idle_found;
  logic                    rel_found;
  logic [WEIGHT_WIDTH-1:0] idle_weight;
  logic [WEIGHT_WIDTH-1:0] rel_weight;
  logic                    release_now;

  // First requester at or after start, wrapping. Offsets are scanned from
  // the far end down so the closest requester is the last one to overwrite.
  function automatic logic [IDX_WIDTH:0] find_from(
    input logic [NUM_PORTS-1:0] req,
    input logic [IDX_WIDTH-1:0] start
  );
    logic                 found;
    logic [IDX_WIDTH-1:0] idx;
    logic [IDX_WIDTH-1:0] pi;
    int                   p;
    found = 1'b0;
    idx   = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      p = int'(start) + off;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      pi = IDX_WIDTH'(p);
      if (req[pi]) begin
        found = 1'b1;
        idx   = pi;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [WEIGHT_WIDTH-1:0] weight_of(
    input logic [NUM_PORTS*WEIGHT_WIDTH-1:0] w_all,
    input logic [IDX_WIDTH-1:0]              sel
  );
    logic [WEIGHT_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == IDX_WIDTH'(i)) w = w_all[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    return w;
  endfunction

  // Two searches run in parallel: one from the stored pointer for an idle
  // grant, one from owner+1 for a handover, so the old owner is checked last.
  always_comb begin
    {idle_found, idle_sel} = find_from(request, pointer);
    next_ptr = (grant_idx == IDX_WIDTH'(NUM_PORTS - 1)) ? '0
                                                         : grant_idx + IDX_WIDTH'(1);
    {rel_found, rel_sel} = find_from(request, next_ptr);
    idle_weight = weight_of(weight, idle_sel);
    rel_weight  = weight_of(weight, rel_sel);
    // A dropped request wins over done; leftover credit is simply discarded.
    release_now = !request[grant_idx] || (done && (credit == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      active    <= 1'b0;
      credit    <= '0;
      pointer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            state     <= OWNED;
            grant     <= NUM_PORTS'(1) << idle_sel;
            grant_idx <= idle_sel;
            active    <= 1'b1;
            credit    <= idle_weight;
          end
        end
        OWNED: begin
          if (release_now) begin
            pointer <= next_ptr;
            if (rel_found) begin
              grant     <= NUM_PORTS'(1) << rel_sel;
              grant_idx <= rel_sel;
              credit    <= rel_weight;
            end else begin
              state  <= IDLE;
              grant  <= '0;
              active <= 1'b0;
            end
          end else if (done) begin
            credit <= credit - WEIGHT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
